// File: rtl/cos_share_arbiter_pkg.sv
// Shared widths, state type and helpers for the cosine-sharing arbiter.
package cos_pkg;

  localparam int SETTLE_CYCLES_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic int xw(input int int_bits, input int dec_bits);
    return int_bits + dec_bits + 1;
  endfunction

  function automatic int yw(input int dec_bits);
    return dec_bits + 2;
  endfunction

  // Never returns 0, so a single-value counter or index still gets one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cos_share_arbiter_cosine.sv
// Combinational cosine: fold into [0, pi/2], then 4-term Taylor series in fixed point.
module cos_unit
  import cos_pkg::*;
#(
  parameter int INT_BITS = 2,
  parameter int DEC_BITS = 8
) (
  input  logic [xw(INT_BITS, DEC_BITS)-1:0] x,
  output logic [yw(DEC_BITS)-1:0]           y
);

  localparam int XW = xw(INT_BITS, DEC_BITS);
  localparam int YW = yw(DEC_BITS);
  localparam int W  = 2 * XW + 2;

  localparam logic [W-1:0] ONE    = W'(1 << DEC_BITS);
  localparam logic [W-1:0] PI_Q   = W'(int'(3.14159265358979 * (2.0 ** DEC_BITS)));
  localparam logic [W-1:0] TWO_PI = W'(int'(6.28318530717959 * (2.0 ** DEC_BITS)));
  localparam logic [W-1:0] HALF   = PI_Q >> 1;

  logic [W-1:0] xs, r, r2, r4, r6, pos, sub, mag, res;
  logic         neg;

  always_comb begin
    xs  = {{(W-XW){x[XW-1]}}, x};
    r   = x[XW-1] ? (~xs + W'(1)) : xs;
    neg = 1'b0;
    if (r >= TWO_PI) r = r - TWO_PI;
    if (r >= PI_Q) begin
      r   = r - PI_Q;
      neg = ~neg;
    end
    if (r > HALF) begin
      r   = PI_Q - r;
      neg = ~neg;
    end
    r2  = (r * r) >> DEC_BITS;
    r4  = (r2 * r2) >> DEC_BITS;
    r6  = (r4 * r2) >> DEC_BITS;
    // Terms are rounded rather than truncated to keep the error bias near zero.
    pos = ONE + (r4 + W'(12)) / W'(24);
    sub = ((r2 + W'(1)) >> 1) + (r6 + W'(360)) / W'(720);
    mag = pos - sub;
    res = neg ? (~mag + W'(1)) : mag;
    y   = YW'(res);
  end

endmodule

// File: rtl/cos_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr, wrapping.
module rr_pick
  import cos_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [clog2(NUM_REQ)-1:0] winner,
  output logic                      any
);

  localparam int IW = clog2(NUM_REQ);

  int idx;

  // Scan from the farthest position back so the nearest one overwrites last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx[IW-1:0]]) begin
        winner = IW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cos_share_arbiter.sv
// Round-robin sharing of one multicycle cosine unit among NUM_REQ requesters.
// Optional one-entry result cache enabled by defining COS_ARB_CACHE_EN.
module cos_share_arbiter
  import cos_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int INT_BITS      = 2,
  parameter int DEC_BITS      = 8,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req,
  input  logic [NUM_REQ*xw(INT_BITS, DEC_BITS)-1:0] x_in,
  output logic [NUM_REQ-1:0]                        grant,
  output logic                                      busy,
  output logic [yw(DEC_BITS)-1:0]                   y_out,
  output logic                                      y_valid,
  output logic [clog2(NUM_REQ)-1:0]                 y_id
);

  localparam int XW = xw(INT_BITS, DEC_BITS);
  localparam int YW = yw(DEC_BITS);
  localparam int IW = clog2(NUM_REQ);
  localparam int CW = clog2(SETTLE_CYCLES);

  state_t         state;
  logic [IW-1:0]  rr_ptr, id_reg, winner, next_ptr;
  logic           any;
  logic [XW-1:0]  x_reg, x_win;
  logic [YW-1:0]  cos_y;
  logic [CW-1:0]  cnt;
  logic           hit;
  logic [YW-1:0]  hit_y;
  logic           capture;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .any    (any)
  );

  // x_reg -> y_out is a multicycle path of SETTLE_CYCLES.
  cos_unit #(.INT_BITS(INT_BITS), .DEC_BITS(DEC_BITS)) u_cos (
    .x (x_reg),
    .y (cos_y)
  );

  assign x_win    = x_in[int'(winner)*XW +: XW];
  assign next_ptr = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
  assign capture  = (state == WAIT) && (cnt == '0);

`ifdef COS_ARB_CACHE_EN
  logic [XW-1:0] cache_x;
  logic [YW-1:0] cache_y;
  logic          cache_vld;

  assign hit   = cache_vld && (x_win == cache_x);
  assign hit_y = cache_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld <= 1'b0;
    end else if (capture) begin
      cache_x   <= x_reg;
      cache_y   <= cos_y;
      cache_vld <= 1'b1;
    end
  end
`else
  assign hit   = 1'b0;
  assign hit_y = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      cnt     <= '0;
      x_reg   <= '0;
      id_reg  <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      y_valid <= 1'b0;
      y_out   <= '0;
      y_id    <= '0;
    end else begin
      grant   <= '0;
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (any) begin
            grant  <= NUM_REQ'(1) << winner;
            rr_ptr <= next_ptr;
            if (hit) begin
              y_valid <= 1'b1;
              y_out   <= hit_y;
              y_id    <= winner;
            end else begin
              x_reg  <= x_win;
              id_reg <= winner;
              cnt    <= CW'(SETTLE_CYCLES - 1);
              busy   <= 1'b1;
              state  <= WAIT;
            end
          end
        end
        WAIT: begin
          // busy stays high through the y_valid cycle; IDLE clears it next edge.
          if (capture) begin
            y_out   <= cos_y;
            y_id    <= id_reg;
            y_valid <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
